// File: rtl/buffer_escritura_reg_pkg.sv
// buffer_escritura_reg_pkg: shared widths, register-zero constant and entry type for the write buffer
package buffer_escritura_reg_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

    localparam logic [AW_DEF-1:0] REG_CERO = '0;

    typedef struct packed {
        logic [AW_DEF-1:0] dir;
        logic [DW_DEF-1:0] dato;
    } entrada_t;

endpackage

// File: rtl/buffer_escritura_reg_if.sv
// buffer_escritura_reg_if: write-back request handshake into the write buffer
interface buffer_escritura_reg_if
    import buffer_escritura_reg_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_dir;
    logic [DW-1:0] in_dato;

    modport master (output in_valid, output in_dir, output in_dato, input in_ready);
    modport slave (input in_valid, input in_dir, input in_dato, output in_ready);

endinterface

// File: rtl/buffer_escritura_reg_fwd_busqueda_reg.sv
// fwd_busqueda_reg: youngest-match search of one lookup address over the held buffer entries
module fwd_busqueda_reg #(
    parameter int DEPTH = 4,
    parameter int AW = 5,
    parameter int DW = 32,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][AW-1:0] dirs,
    input  logic [DEPTH-1:0][DW-1:0] datos,
    input  logic [PW-1:0]            rp,
    input  logic [CW-1:0]            cnt,
    input  logic [AW-1:0]            addr,
    output logic                     hit,
    output logic [DW-1:0]            dato
);

    // Walk from oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit = 1'b0;
        dato = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < cnt && addr != '0 && dirs[rp + PW'(k)] == addr) begin
                hit = 1'b1;
                dato = datos[rp + PW'(k)];
            end
        end
    end

endmodule

// File: rtl/buffer_escritura_reg.sv
// buffer_escritura_reg: write-back buffer draining into the register file write port, with forwarding lookups
// Optional build macro BUFFER_ESCRITURA_COALESCE_EN merges a request into a held entry of the same address.
module buffer_escritura_reg
    import buffer_escritura_reg_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    buffer_escritura_reg_if.slave        wr,
    input  logic                         puerto_libre,
    output logic                         regEscribir,
    output logic [AW-1:0]                C,
    output logic [DW-1:0]                WE,
    input  logic [AW-1:0]                A,
    input  logic [AW-1:0]                B,
    output logic                         fwdA,
    output logic                         fwdB,
    output logic [DW-1:0]                datoA,
    output logic [DW-1:0]                datoB,
    output logic [$clog2(DEPTH+1)-1:0]   ocupacion
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][AW-1:0] dirs;
    logic [DEPTH-1:0][DW-1:0] datos;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] cnt;
    logic pop;
    logic fire;
    logic push;
    logic fusion;

    assign pop = (cnt != '0) && puerto_libre;
    assign wr.in_ready = (cnt != CW'(DEPTH)) || fusion;
    assign fire = wr.in_valid && wr.in_ready;
    assign push = fire && wr.in_dir != '0 && !fusion;

`ifdef BUFFER_ESCRITURA_COALESCE_EN
    logic coin;
    logic [PW-1:0] coin_idx;

    // Find the held entry with the request's address; a head leaving this cycle cannot absorb it.
    always_comb begin
        coin = 1'b0;
        coin_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ({1'b0, PW'(PW'(i) - rp)} < cnt && dirs[i] == wr.in_dir && wr.in_dir != '0) begin
                coin = 1'b1;
                coin_idx = PW'(i);
            end
        end
    end

    assign fusion = coin && !(pop && coin_idx == rp);
`else
    assign fusion = 1'b0;
`endif

    // Pointers and occupancy; reset empties the buffer without touching the storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + PW'(1);
            if (pop) rp <= rp + PW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    // Entry storage: new requests at the tail, merged requests rewrite data in place.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            dirs[wp] <= wr.in_dir;
            datos[wp] <= wr.in_dato;
        end
`ifdef BUFFER_ESCRITURA_COALESCE_EN
        if (!rst && fire && fusion) datos[coin_idx] <= wr.in_dato;
`endif
    end

    assign regEscribir = pop;
    assign C = pop ? dirs[rp] : '0;
    assign WE = pop ? datos[rp] : '0;
    assign ocupacion = cnt;

    fwd_busqueda_reg #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .dirs (dirs),
        .datos(datos),
        .rp   (rp),
        .cnt  (cnt),
        .addr (A),
        .hit  (fwdA),
        .dato (datoA)
    );

    fwd_busqueda_reg #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .dirs (dirs),
        .datos(datos),
        .rp   (rp),
        .cnt  (cnt),
        .addr (B),
        .hit  (fwdB),
        .dato (datoB)
    );

endmodule
